aes_inv_round_unit: RTL and testbench
=====================================

// Module: aes_inv_round_unit
// PURPOSE
// - Registered AES inverse-cipher round datapath: InvSubBytes -> AddRoundKey -> InvMixColumns.
// - Sits after the external InvShiftRows stage in the inverse-cipher state machine.
// - Input state is already row-shifted; one round (or partial round, per Mode) per accepted beat.
// - Fixed 1-cycle latency.
// PARAMETERS
// - Nb  4   state columns (32-bit words per round key)
// - Nr  10  number of rounds; key schedule holds Nb*(Nr+1) words
// PORTS
// - clk        in   1          clock
// - rst        in   1          reset, synchronous, active-low
// - IBox       in   8 x[256]   inverse S-box table
// - EXP3       in   8 x[256]   GF(2^8) antilog table, generator 0x03
// - LN3        in   8 x[256]   GF(2^8) log table, generator 0x03
// - KExp       in   32 x[Nb*(Nr+1)]  expanded key schedule
// - State_in   in   8 x[4*Nb]  input state; byte i = column i/4, row i%4
// - Index      in   4          round-key index 0..Nr
// - Mode       in   2          0=ARK, 1=ISB+ARK+IMC, 2=ISB+ARK, 3=IMC only
// - Valid_in   in   1          State_in/Index/Mode valid this cycle
// - State_out  out  8 x[4*Nb]  registered result
// - Valid_out  out  1          State_out updated last edge
// BEHAVIOUR
// - Reset (rst==0 at posedge): State_out all 0x00, Valid_out=0; overrides Valid_in.
//   A beat in flight during reset is dropped.
// - Valid_in=1 at posedge: State_out <= f(State_in,Index,Mode); Valid_out <= 1.
// - Valid_in=0 at posedge: State_out holds; Valid_out <= 0.
// - Back-to-back beats every cycle are accepted.
// - No backpressure: the consumer samples State_out when Valid_out=1.
// - InvSubBytes: byte b -> IBox[b] for all 16 bytes.
// - AddRoundKey: for column c, w = KExp[Index*Nb + c]; row r byte ^= w[31-8r -: 8]
//   (row 0 = MSB).
// - Index > Nr: round key forced to zero, so ARK passes data through; no error flag.
// - InvMixColumns, per column (s0..s3), all arithmetic in GF(2^8) mod 0x11B:
//   - s0' = 0e*s0 ^ 0b*s1 ^ 0d*s2 ^ 09*s3
//   - s1' = 09*s0 ^ 0e*s1 ^ 0b*s2 ^ 0d*s3
//   - s2' = 0d*s0 ^ 09*s1 ^ 0e*s2 ^ 0b*s3
//   - s3' = 0b*s0 ^ 0d*s1 ^ 09*s2 ^ 0e*s3
// - Mode 0 = ARK(State_in).
// - Mode 1 = IMC(ARK(ISB(State_in))).
// - Mode 2 = ARK(ISB(State_in)).
// - Mode 3 = IMC(State_in); Index ignored.
// - All datapath logic is combinational between State_in and the output register.
// CONFIGURATION
// - AES_IMC_LUT_EN defined: GF multiply uses tables:
//   a*b = (a==0 || b==0) ? 0 : EXP3[(LN3[a]+LN3[b]) mod 255], 9-bit sum before the mod.
// - AES_IMC_LUT_EN undefined: GF multiply uses xtime shift/xor chains; EXP3/LN3 ports
//   remain but are unused.
// - Results must be bit-identical in both builds.
// TESTING
// - Reset: hold rst=0 for 2 cycles with Valid_in=1 -> State_out=0, Valid_out=0.
// - ISB: Mode 2, KExp all zero, State_in all 0x16 -> all 0xFF; all 0x00 -> all 0x52.
// - ARK: Mode 0, Index 0, KExp[0..3]=2b7e1516 28aed2a6 abf71588 09cf4f3c, state 0
//   -> bytes 2b 7e 15 16 28 ae ... 4f 3c.
// - IMC: Mode 3, every column 8e 4d a1 bc -> every column db 13 53 45;
//   also all 0x01 -> all 0x01.
// - Full round: Mode 1, KExp zero, column 8e 4d a1 bc pre-substituted via S-box
//   -> column db 13 53 45; repeat in both AES_IMC_LUT_EN builds.
// - Handshake: Valid_in pulses 1,0,1 with distinct states -> Valid_out 1,0,1 one cycle
//   later; State_out holds during the 0 cycle; Index=15 -> ARK pass-through.

Source files
------------

// File: rtl/aes_inv_round_if.sv
// Handshake bundle for the AES inverse round unit.
//   State_in  : 4*Nb input bytes; byte i = column i/4, row i%4
//   Index     : round-key index 0..Nr (larger values give a zero round key)
//   Mode      : 0=ARK, 1=ISB+ARK+IMC, 2=ISB+ARK, 3=IMC only
//   Valid_in  : State_in/Index/Mode valid this cycle
//   State_out : registered result
//   Valid_out : State_out was updated on the last edge
// master = beat producer / result consumer, slave = round unit.
interface aes_inv_round_if #(
  parameter int Nb = 4
);
  logic [7:0] State_in  [4*Nb];
  logic [3:0] Index;
  logic [1:0] Mode;
  logic       Valid_in;
  logic [7:0] State_out [4*Nb];
  logic       Valid_out;

  modport master (
    output State_in, Index, Mode, Valid_in,
    input  State_out, Valid_out
  );

  modport slave (
    input  State_in, Index, Mode, Valid_in,
    output State_out, Valid_out
  );
endinterface

// File: rtl/aes_inv_round_unit.sv
// AES inverse-cipher round datapath: InvSubBytes -> AddRoundKey -> InvMixColumns,
// selected per beat by Mode, with a single output register (1-cycle latency).
// The incoming state is already row-shifted by the upstream InvShiftRows stage.
// Ports:
//   clk   : clock
//   rst   : synchronous, active-low reset (clears State_out, Valid_out)
//   IBox  : inverse S-box table
//   EXP3  : GF(2^8) antilog table, generator 0x03
//   LN3   : GF(2^8) log table, generator 0x03
//   KExp  : expanded key schedule, Nb*(Nr+1) words
//   bus   : aes_inv_round_if.slave (State_in/Index/Mode/Valid_in, State_out/Valid_out)
// Build option:
//   AES_IMC_LUT_EN defined   -> GF multiplies use the EXP3/LN3 tables
//   AES_IMC_LUT_EN undefined -> GF multiplies use xtime shift/xor; EXP3/LN3 unused
module aes_inv_round_unit #(
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  IBox [256],
  input  logic [7:0]  EXP3 [256],
  input  logic [7:0]  LN3  [256],
  input  logic [31:0] KExp [Nb*(Nr+1)],
  aes_inv_round_if.slave bus
);

  localparam logic [3:0] NR4 = 4'(Nr);

  logic [7:0]  sub_b [4*Nb];
  logic [7:0]  ark_b [4*Nb];
  logic [7:0]  nxt_b [4*Nb];
  logic [7:0]  state_q [4*Nb];
  logic [31:0] rk [Nb];
  logic [5:0]  kidx;
  logic        valid_q;
  logic        use_isb, use_ark, use_imc;

`ifdef AES_IMC_LUT_EN
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    s = {1'b0, LN3[a]} + {1'b0, LN3[b]};
    if (s >= 9'd255) s = s - 9'd255;
    return EXP3[s[7:0]];
  endfunction
`else
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Tables are kept on the port list for build compatibility only.
  logic unused_tables;
  always_comb begin
    unused_tables = 1'b0;
    for (int i = 0; i < 256; i++) unused_tables = unused_tables ^ (^EXP3[i]) ^ (^LN3[i]);
  end
`endif

  function automatic logic [31:0] inv_mix(input logic [7:0] s0, input logic [7:0] s1,
                                          input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] r0, r1, r2, r3;
    r0 = gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09);
    r1 = gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d);
    r2 = gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b);
    r3 = gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e);
    return {r0, r1, r2, r3};
  endfunction

  assign use_isb = (bus.Mode == 2'd1) || (bus.Mode == 2'd2);
  assign use_ark = (bus.Mode != 2'd3);
  assign use_imc = (bus.Mode == 2'd1) || (bus.Mode == 2'd3);

  always_comb begin
    kidx = 6'd0;
    for (int c = 0; c < Nb; c++) begin
      kidx  = 6'(bus.Index) * 6'(Nb) + 6'(c);
      // Out-of-range index: zero key, so ARK degenerates to a pass-through.
      rk[c] = (bus.Index <= NR4) ? KExp[kidx] : 32'h0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4*Nb; i++) begin
      sub_b[i] = use_isb ? IBox[bus.State_in[i]] : bus.State_in[i];
      // Row 0 sits in the MSB of each key word.
      ark_b[i] = use_ark ? (sub_b[i] ^ rk[i/4][31-8*(i%4) -: 8]) : sub_b[i];
      nxt_b[i] = ark_b[i];
    end
    if (use_imc) begin
      for (int c = 0; c < Nb; c++) begin
        {nxt_b[4*c], nxt_b[4*c+1], nxt_b[4*c+2], nxt_b[4*c+3]} =
          inv_mix(ark_b[4*c], ark_b[4*c+1], ark_b[4*c+2], ark_b[4*c+3]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4*Nb; i++) state_q[i] <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.Valid_in;
      if (bus.Valid_in) begin
        for (int i = 0; i < 4*Nb; i++) state_q[i] <= nxt_b[i];
      end
    end
  end

  assign bus.State_out = state_q;
  assign bus.Valid_out = valid_q;

endmodule

// File: tb/tb_aes_inv_round_unit.sv
// Directed bench for aes_inv_round_unit. Builds the S-box / log tables from
// GF(2^8) arithmetic, then steps through reset, ISB, ARK, IMC, full-round and
// handshake vectors with hand-derived expected results.
module tb_aes_inv_round_unit;
  logic        clk;
  logic        rst;
  logic [7:0]  ibox [256];
  logic [7:0]  sbox [256];
  logic [7:0]  exp3 [256];
  logic [7:0]  ln3  [256];
  logic [31:0] kexp [44];
  int          n_pass;
  int          n_total;

  aes_inv_round_if #(.Nb(4)) bus ();

  aes_inv_round_unit #(.Nb(4), .Nr(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .IBox (ibox),
    .EXP3 (exp3),
    .LN3  (ln3),
    .KExp (kexp),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] packed_out();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = bus.State_out[i];
    return v;
  endfunction

  task automatic set_state(input logic [127:0] v);
    for (int i = 0; i < 16; i++) bus.State_in[i] = v[127-8*i -: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [127:0] expv);
    logic [127:0] obs;
    obs = packed_out();
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s state_out got %h expected %h", tag, obs, expv);
  endtask

  task automatic check_valid(input string tag, input logic expv);
    logic obs;
    obs = bus.Valid_out;
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s valid_out got %b expected %b", tag, obs, expv);
  endtask

  logic [127:0] key0, key1, st_a, st_b, col_sb;

  initial begin
    logic [7:0] p, inv, s;
    n_pass  = 0;
    n_total = 0;

    // Log/antilog tables for generator 0x03, then forward and inverse S-box.
    p = 8'h01;
    ln3[0] = 8'h00;
    for (int i = 0; i < 255; i++) begin
      exp3[i] = p;
      ln3[p]  = 8'(i);
      p = p ^ xt(p);
    end
    exp3[255] = 8'h01;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp3[(255 - int'(ln3[x])) % 255];
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      ibox[s] = 8'(x);
    end
    for (int i = 0; i < 44; i++) kexp[i] = 32'h0;

    key0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    key1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    // Reset held two cycles while a beat is offered.
    rst = 1'b0;
    bus.Valid_in = 1'b1;
    bus.Mode  = 2'd1;
    bus.Index = 4'd0;
    set_state(128'h0123456789abcdef_fedcba9876543210);
    tick();
    tick();
    check_valid("reset_valid", 1'b0);
    check_state("reset_state", 128'h0);

    rst = 1'b1;

    // InvSubBytes only (zero key).
    bus.Mode = 2'd2;
    set_state({16{8'h16}});
    tick();
    check_valid("isb16_valid", 1'b1);
    check_state("isb16", {16{8'hff}});
    set_state({16{8'h00}});
    tick();
    check_state("isb00", {16{8'h52}});

    // AddRoundKey with round 0 and round 1 keys.
    for (int c = 0; c < 4; c++) begin
      kexp[c]     = key0[127-32*c -: 32];
      kexp[4 + c] = key1[127-32*c -: 32];
    end
    bus.Mode  = 2'd0;
    bus.Index = 4'd0;
    set_state(128'h0);
    tick();
    check_state("ark_idx0", key0);
    bus.Index = 4'd1;
    set_state(key0);
    tick();
    check_state("ark_idx1", key0 ^ key1);
    bus.Index = 4'd10;
    set_state(key1);
    tick();
    check_state("ark_idx10_zero", key1);

    // ISB then ARK with a non-zero key.
    bus.Mode  = 2'd2;
    bus.Index = 4'd0;
    set_state({16{8'h16}});
    tick();
    check_state("isb_ark", {128{1'b1}} ^ key0);

    // InvMixColumns only; Index must not matter.
    bus.Mode  = 2'd3;
    bus.Index = 4'd0;
    set_state({4{32'h8e4da1bc}});
    tick();
    check_state("imc_col", {4{32'hdb135345}});
    set_state({16{8'h01}});
    tick();
    check_state("imc_ones", {16{8'h01}});

    // Full round, zero key at index 2, input pre-substituted through the S-box.
    col_sb = {4{sbox[8'h8e], sbox[8'h4d], sbox[8'ha1], sbox[8'hbc]}};
    bus.Mode  = 2'd1;
    bus.Index = 4'd2;
    set_state(col_sb);
    tick();
    check_state("full_round", {4{32'hdb135345}});

    // Handshake 1,0,1 with out-of-range index (pass-through ARK).
    st_a = 128'h00112233_44556677_8899aabb_ccddeeff;
    st_b = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    bus.Mode  = 2'd0;
    bus.Index = 4'd15;
    bus.Valid_in = 1'b1;
    set_state(st_a);
    tick();
    check_valid("hs_v1", 1'b1);
    check_state("hs_s1", st_a);
    bus.Valid_in = 1'b0;
    set_state(st_b);
    tick();
    check_valid("hs_v0", 1'b0);
    check_state("hs_hold", st_a);
    bus.Valid_in = 1'b1;
    tick();
    check_valid("hs_v2", 1'b1);
    check_state("hs_s2", st_b);

    // Back-to-back beats.
    set_state(st_a);
    tick();
    check_state("b2b_1", st_a);
    set_state(key0);
    tick();
    check_valid("b2b_valid", 1'b1);
    check_state("b2b_2", key0);

    // Reset mid-stream drops the offered beat.
    rst = 1'b0;
    set_state(st_b);
    tick();
    check_valid("rst2_valid", 1'b0);
    check_state("rst2_state", 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
